riscv_div_iter: RTL

Iterative 32-bit RISC-V M-extension divide/remainder unit with a valid/ready request/response handshake. It executes the four divide operations, func3 100–111, over multiple cycles using radix-2 restoring division, so the 32-bit divider stays off the combinational execute path. It sits beside the combinational multiply unit in execute; the core issues to it and stalls until the response handshake completes.

---
 rtl/riscv_md_pkg.sv | 10 +
 rtl/riscv_div_iter_if.sv | 13 +
 rtl/div_iter_step.sv | 17 +
 rtl/riscv_div_iter.sv | 70 +++++++
 4 files changed

// File: rtl/riscv_md_pkg.sv
// riscv_md_pkg: shared func3 codes, divider state encoding and special-case constants
package riscv_md_pkg;
  localparam logic [2:0] F3_DIV = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;
  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;
  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;
endpackage

// File: rtl/riscv_div_iter_if.sv
// riscv_div_iter_if: request/response handshake bundle of the iterative divider
interface riscv_div_iter_if;
  logic req_valid;
  logic req_ready;
  logic [2:0] func3;
  logic [31:0] input1;
  logic [31:0] input2;
  logic resp_valid;
  logic resp_ready;
  logic [31:0] result;
  modport master(output req_valid, func3, input1, input2, resp_ready, input req_ready, resp_valid, result);
  modport slave(input req_valid, func3, input1, input2, resp_ready, output req_ready, resp_valid, result);
endinterface

// File: rtl/div_iter_step.sv
// div_iter_step: one radix-2 restoring division step on {rem, quo}
module div_iter_step (
  input logic [31:0] rem,
  input logic [31:0] quo,
  input logic [31:0] dvsr,
  output logic [31:0] rem_n,
  output logic [31:0] quo_n
);
  logic [32:0] sh, diff;
  // rem < dvsr on entry, so a 33-bit trial subtract sign is exact
  always_comb begin
    sh = {rem, quo[31]};
    diff = sh - {1'b0, dvsr};
    rem_n = diff[32] ? sh[31:0] : diff[31:0];
    quo_n = {quo[30:0], ~diff[32]};
  end
endmodule

// File: rtl/riscv_div_iter.sv
// riscv_div_iter: iterative RV32M DIV/DIVU/REM/REMU unit; RISCV_DIV_EARLY_OUT_EN enables |a|<|b| shortcut
module riscv_div_iter
  import riscv_md_pkg::*;
(
  input logic clk,
  input logic rst,
  input logic flush,
  riscv_div_iter_if.slave bus
);
  state_t state, nxt;
  logic [31:0] rem, quo, dvsr, rem_n, quo_n, a_mag, b_mag, result;
  logic [4:0] cnt;
  logic neg_q, neg_r, is_rem, sgn, div0, ovf, early, short_cut, accept, unused_f3;
  assign unused_f3 = bus.func3[2];
  assign sgn = ~bus.func3[0];
  assign a_mag = (sgn && bus.input1[31]) ? -bus.input1 : bus.input1;
  assign b_mag = (sgn && bus.input2[31]) ? -bus.input2 : bus.input2;
  assign div0 = bus.input2 == '0;
  assign ovf = sgn && bus.input1 == INT_MIN && bus.input2 == '1;
`ifdef RISCV_DIV_EARLY_OUT_EN
  assign early = a_mag < b_mag;
`else
  assign early = 1'b0;
`endif
  assign short_cut = div0 || ovf || early;
  assign bus.req_ready = state == IDLE && !flush && !rst;
  assign accept = bus.req_valid && bus.req_ready;
  assign bus.resp_valid = state == DONE;
  assign bus.result = result;
  div_iter_step u_step (.rem(rem), .quo(quo), .dvsr(dvsr), .rem_n(rem_n), .quo_n(quo_n));
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  // shortcuts preload quo/rem and pass through FIXUP so they share its result select
  always_comb begin
    nxt = state;
    nxt = flush ? IDLE :
          state == IDLE ? (accept ? (short_cut ? FIXUP : CALC) : IDLE) :
          state == CALC ? (cnt == '0 ? FIXUP : CALC) :
          state == FIXUP ? DONE :
          (bus.resp_ready ? IDLE : DONE);
  end
  // operand capture, iteration and sign fixup
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rem <= '0;
      quo <= '0;
      dvsr <= '0;
      cnt <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      is_rem <= 1'b0;
      result <= '0;
    end else if (accept) begin
      dvsr <= b_mag;
      cnt <= 5'd31;
      is_rem <= bus.func3[1];
      quo <= div0 ? DIV0_QUOT : ovf ? INT_MIN : early ? '0 : a_mag;
      rem <= (div0 || early) ? bus.input1 : '0;
      neg_q <= !short_cut && sgn && (bus.input1[31] ^ bus.input2[31]);
      neg_r <= !short_cut && sgn && bus.input1[31];
    end else if (state == CALC) begin
      rem <= rem_n;
      quo <= quo_n;
      cnt <= cnt - 5'd1;
    end else if (state == FIXUP && !flush) begin
      result <= is_rem ? (neg_r ? -rem : rem) : (neg_q ? -quo : quo);
    end
endmodule
